horner_datapath: RTL and testbench

- Arithmetic datapath for the polynomial (Horner) evaluation engine, directly downstream of the sequencing controller.
- Consumes the controller strobes (redo, LD_coeff, LD_signal, LD_result) together with the signal- and coefficient-FIFO read data.
- Performs the alternating fixed-point add and multiply steps.
- Each finished result goes into a small output FIFO with a valid/ready handshake toward the consumer.

---
 rtl/horner_datapath.sv | 162 ++++++++++++++++
 tb/tb_horner_datapath.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_datapath.sv
// Horner evaluation datapath: saturating add step, two-stage rounding multiply,
// and a small first-word-fall-through result FIFO with sticky error flags.
module horner_datapath #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 8,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redo,
  input  logic              LD_coeff,
  input  logic              LD_signal,
  input  logic              LD_result,
  input  logic [DATA_W-1:0] coeff_in,
  input  logic [DATA_W-1:0] signal_in,
  output logic [DATA_W-1:0] result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              sat_err,
  output logic              drop_err
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic signed [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] RndConst = PROD_W'(1) << (FRAC_W - 1);

  logic signed [DATA_W-1:0] sum_q, sum_d;
  logic signed [DATA_W-1:0] prod_q, prod_d;
  logic signed [PROD_W-1:0] mul_q, mul_d;
  logic                     mul_vld_q, mul_vld_d;
  logic                     sat_err_q, sat_err_d;
  logic                     drop_err_q, drop_err_d;

  logic signed [DATA_W-1:0] coeff_s, signal_s;
  logic signed [DATA_W:0]   add_full;
  logic                     add_ovf;
  logic signed [DATA_W-1:0] add_res;
  logic signed [PROD_W-1:0] mul_full;
  logic signed [PROD_W-1:0] mul_rnd;
  logic signed [PROD_W-1:0] mul_shr;
  logic                     mul_ovf;
  logic signed [DATA_W-1:0] mul_res;
  logic                     mul_start;

  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fifo_full, fifo_pop, fifo_push, fifo_drop;

  assign coeff_s  = $signed(coeff_in);
  assign signal_s = $signed(signal_in);

  // Add step arithmetic: one guard bit catches overflow before clamping.
  always_comb begin
    add_full = {prod_q[DATA_W-1], prod_q} + {coeff_s[DATA_W-1], coeff_s};
    add_ovf  = add_full[DATA_W] != add_full[DATA_W-1];
    add_res  = add_ovf ? (add_full[DATA_W] ? MinVal : MaxVal) : add_full[DATA_W-1:0];
  end

  // Multiply arithmetic: full product for stage 0, round-half-up and clamp for stage 1.
  always_comb begin
    mul_full = PROD_W'(sum_q) * PROD_W'(signal_s);
    mul_rnd  = mul_q + RndConst;
    mul_shr  = mul_rnd >>> FRAC_W;
    mul_ovf  = 1'b0;
    mul_res  = mul_shr[DATA_W-1:0];
    if (mul_shr > PROD_W'(MaxVal)) begin
      mul_ovf = 1'b1;
      mul_res = MaxVal;
    end else if (mul_shr < PROD_W'(MinVal)) begin
      mul_ovf = 1'b1;
      mul_res = MinVal;
    end
  end

  // Strobe decode: redo dominates, then LD_coeff over LD_signal.
  always_comb begin
    sum_d     = sum_q;
    prod_d    = prod_q;
    mul_d     = mul_q;
    mul_vld_d = 1'b0;
    sat_err_d = sat_err_q;
    mul_start = LD_signal & ~LD_coeff & ~redo;
    if (redo) begin
      // An in-flight product is discarded along with the accumulators.
      sum_d  = '0;
      prod_d = '0;
    end else begin
      if (mul_vld_q) begin
        prod_d = mul_res;
        if (mul_ovf) sat_err_d = 1'b1;
      end
      if (LD_coeff) begin
        sum_d = add_res;
        if (add_ovf) sat_err_d = 1'b1;
      end else if (LD_signal) begin
        mul_d     = mul_full;
        mul_vld_d = 1'b1;
      end
    end
    busy = mul_vld_q | mul_start;
  end

  // Output FIFO control: a pop frees a full slot for a same-cycle push.
  always_comb begin
    fifo_full  = cnt_q == CNT_W'(OUT_DEPTH);
    fifo_pop   = (cnt_q != '0) & result_ready;
    fifo_push  = LD_result & (~fifo_full | fifo_pop);
    fifo_drop  = LD_result & fifo_full & ~fifo_pop;
    wr_ptr_d   = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q;
    drop_err_d = drop_err_q | fifo_drop;
    unique case ({fifo_push, fifo_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      prod_q     <= '0;
      mul_q      <= '0;
      mul_vld_q  <= 1'b0;
      sat_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      sum_q      <= sum_d;
      prod_q     <= prod_d;
      mul_q      <= mul_d;
      mul_vld_q  <= mul_vld_d;
      sat_err_q  <= sat_err_d;
      drop_err_q <= drop_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && fifo_push) mem_q[wr_ptr_q] <= sum_q;
  end

  assign result_valid = cnt_q != '0;
  assign result_data  = result_valid ? mem_q[rd_ptr_q] : '0;
  assign sat_err      = sat_err_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_horner_datapath.sv
// Bench for horner_datapath: directed scenarios with literal expectations plus
// constrained-random strobes, all checked every cycle against a behavioural model.
module tb_horner_datapath;

  localparam int DATA_W    = 16;
  localparam int FRAC_W    = 8;
  localparam int OUT_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redo = 1'b0, LD_coeff = 1'b0, LD_signal = 1'b0, LD_result = 1'b0;
  logic [DATA_W-1:0] coeff_in = '0, signal_in = '0;
  logic [DATA_W-1:0] result_data;
  logic              result_valid, result_ready = 1'b1;
  logic              busy, sat_err, drop_err;

  int n_cmp = 0;
  int n_bad = 0;

  horner_datapath #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .redo         (redo),
    .LD_coeff     (LD_coeff),
    .LD_signal    (LD_signal),
    .LD_result    (LD_result),
    .coeff_in     (coeff_in),
    .signal_in    (signal_in),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .sat_err      (sat_err),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_sum, m_prod, m_mul;
  bit     m_pend, m_sat, m_drop, model_ok;
  longint m_q[$];

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  always @(posedge clk) begin
    longint p0, v;
    if (rst) begin
      m_sum = 0; m_prod = 0; m_mul = 0; m_pend = 0; m_sat = 0; m_drop = 0;
      m_q.delete();
      model_ok = 1;
    end else if (model_ok) begin
      if (m_q.size() > 0 && result_ready) void'(m_q.pop_front());
      if (LD_result) begin
        if (m_q.size() < OUT_DEPTH) m_q.push_back(m_sum);
        else m_drop = 1;
      end
      if (redo) begin
        m_sum = 0; m_prod = 0; m_pend = 0;
      end else begin
        p0 = m_prod;
        if (m_pend) begin
          v = (m_mul + 128) >>> FRAC_W;
          if (clamp(v) != v) m_sat = 1;
          m_prod = clamp(v);
          m_pend = 0;
        end
        if (LD_coeff) begin
          v = p0 + longint'($signed(coeff_in));
          if (clamp(v) != v) m_sat = 1;
          m_sum = clamp(v);
        end else if (LD_signal) begin
          m_mul  = m_sum * longint'($signed(signal_in));
          m_pend = 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("valid", longint'(result_valid), longint'(m_q.size() != 0));
      chk("data", longint'($signed(result_data)), (m_q.size() != 0) ? m_q[0] : 0);
      chk("busy", longint'(busy), longint'(m_pend | (LD_signal & ~LD_coeff & ~redo)));
      chk("sat_err", longint'(sat_err), longint'(m_sat));
      chk("drop_err", longint'(drop_err), longint'(m_drop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit r, input bit lc, input bit ls, input bit lr,
                       input int c, input int s);
    redo = r; LD_coeff = lc; LD_signal = ls; LD_result = lr;
    coeff_in = DATA_W'(c); signal_in = DATA_W'(s);
    @(posedge clk); #1;
    redo = 0; LD_coeff = 0; LD_signal = 0; LD_result = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Multiply then leave three cycles before any further add.
  task automatic mul(input int s);
    drive(0, 0, 1, 0, 0, s);
    idle(2);
  endtask

  // Copy prod_reg into sum_reg, push it, and check the head literally.
  task automatic readout(input string name, input int exp);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk(name, longint'($signed(result_data)), exp);
  endtask

  task automatic prod_case(input string name, input int s0, input int sig, input int exp);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, s0, 0);
    mul(sig);
    readout(name, exp);
    idle(2);
  endtask

  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
  endtask

  initial begin
    int gap;
    bit r, lc, ls, lr;
    int c, s, x;

    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst valid", longint'(result_valid), 0);
    chk("rst data", longint'(result_data), 0);
    chk("rst busy", longint'(busy), 0);

    // Basic evaluation: 1.0 * 2.0 + 1.0 = 3.0
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 256, 0);
    drive(0, 0, 1, 0, 0, 512);
    @(negedge clk); chk("busy stage1", longint'(busy), 1);
    idle(1);
    @(negedge clk); chk("busy done", longint'(busy), 0);
    idle(1);
    drive(0, 1, 0, 0, 256, 0);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("eval valid", longint'(result_valid), 1);
    chk("eval 3.0", longint'($signed(result_data)), 768);
    chk("eval sat", longint'(sat_err), 0);
    idle(2);

    // Rounding
    prod_case("rnd 1*128", 1, 128, 1);
    prod_case("rnd -1*128", -1, 128, 0);
    prod_case("rnd 3*-128", 3, -128, -1);

    // Saturation
    prod_case("sat pos", 32000, 512, 32767);
    chk("sat flag", longint'(sat_err), 1);
    drive(0, 1, 0, 0, 100, 0);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("sat add", longint'($signed(result_data)), 32767);
    idle(2);
    prod_case("sat neg", -32000, 512, -32768);

    // Reset one cycle after LD_signal with one entry queued
    result_ready = 0;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 300, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 256);
    do_reset();
    @(negedge clk);
    chk("rst2 valid", longint'(result_valid), 0);
    chk("rst2 data", longint'(result_data), 0);
    chk("rst2 busy", longint'(busy), 0);
    chk("rst2 sat", longint'(sat_err), 0);
    result_ready = 1;
    idle(2);
    readout("rst2 prod", 0);
    idle(2);

    // FIFO overflow
    result_ready = 0;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 10, 0); drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 20, 0); drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 30, 0); drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("fifo drop", longint'(drop_err), 1);
    chk("fifo head0", longint'($signed(result_data)), 10);
    result_ready = 1;
    @(posedge clk); #1; @(negedge clk);
    chk("fifo head1", longint'($signed(result_data)), 20);
    @(posedge clk); #1; @(negedge clk);
    chk("fifo empty", longint'(result_valid), 0);

    // Full with simultaneous push and pop: no drop
    do_reset();
    result_ready = 0;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 40, 0); drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 50, 0); drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 60, 0);
    result_ready = 1;
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("full pp drop", longint'(drop_err), 0);
    chk("full pp head", longint'($signed(result_data)), 50);
    idle(3);

    // redo with LD_result pushes the pre-clear sum
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 768, 0);
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk); chk("redo push", longint'($signed(result_data)), 768);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("redo cleared", longint'($signed(result_data)), 0);
    chk("redo cleared v", longint'(result_valid), 1);
    idle(2);

    // redo one cycle after LD_signal cancels the multiply
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 5, 0);
    drive(0, 0, 1, 0, 0, 256);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("cancel busy", longint'(busy), 0);
    idle(1);
    readout("cancel prod", 0);
    idle(2);

    // Constrained-random strobes; LD_coeff/LD_signal keep a 3-cycle gap after a multiply
    gap = 3;
    for (int i = 0; i < 3000; i++) begin
      x  = $urandom_range(0, 99);
      r  = x < 8;
      lc = 0; ls = 0;
      if (gap >= 3) begin
        if (x < 8) lc = $urandom_range(0, 1) == 0;
        else if (x < 40) lc = 1;
        else if (x < 60) ls = 1;
        else if (x < 63) begin lc = 1; ls = 1; end
      end
      lr = $urandom_range(0, 3) == 0;
      c  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1200)) - 600
                                       : int'($urandom_range(0, 65535)) - 32768;
      s  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1024)) - 512
                                       : int'($urandom_range(0, 65535)) - 32768;
      result_ready = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 199) == 0;
      gap = ls ? 0 : gap + 1;
      drive(r, lc, ls, lr, c, s);
      rst = 0;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
